prbs_checker: RTL

Serial pseudo-random bit-stream checker, the receive-side partner of the team's 4-bit LFSR generator. It accepts a serial stream produced by the x^4+x^3+1 recurrence b[n] = b[n-3] ^ b[n-4] (period 15), self-synchronises to it, and then free-runs a local copy. It reports lock status, per-bit error pulses and saturating bit/error counters. It sits at the far end of a link or loopback path under test.

---
 rtl/prbs_checker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// Receive-side checker for the x^4+x^3+1 PRBS stream (period 15).
// It self-synchronises to the stream, then free-runs a local LFSR and counts bit errors.
module prbs_checker #(
   parameter int LOCK_CNT   = 8,
   parameter int UNLOCK_ERR = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din_valid,
   input  logic             din,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] bit_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [7:0]       LOCK_LAST   = 8'(LOCK_CNT - 1);
   localparam logic [7:0]       UNLOCK_LAST = 8'(UNLOCK_ERR - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state_q, state_d;
   logic [3:0]       sh_q, sh_d;
   logic [2:0]       fill_q, fill_d;
   logic [7:0]       match_q, match_d;
   logic [7:0]       cerr_q, cerr_d;
   logic [CNT_W-1:0] bit_d, err_d;
   logic             pulse_d;

   logic pred;
   logic mismatch;
   logic filled;

   // sh[0] holds the newest bit, so sh[3]/sh[2] are b[n-4]/b[n-3].
   assign pred     = sh_q[2] ^ sh_q[3];
   assign mismatch = (din != pred);
   assign filled   = (fill_q == 3'd4);

   always_comb begin
      // NOTE: every output of this block gets a default first, otherwise any path
      // that skips an assignment would infer a latch.
      state_d = state_q;
      sh_d    = sh_q;
      fill_d  = fill_q;
      match_d = match_q;
      cerr_d  = cerr_q;
      bit_d   = bit_cnt;
      err_d   = err_cnt;
      pulse_d = 1'b0;

      if (din_valid) begin
         case (state_q)
            SEARCH: begin
               sh_d = {sh_q[2:0], din};
               if (!filled) begin
                  fill_d = fill_q + 3'd1;
               end else if (!mismatch && (sh_q != 4'b0000)) begin
                  if (match_q == LOCK_LAST) begin
                     state_d = LOCKED;
                     match_d = '0;
                  end else begin
                     match_d = match_q + 8'd1;
                  end
               end else begin
                  // An all-zero register would "predict" an all-zero stream forever.
                  match_d = '0;
               end
            end

            LOCKED: begin
               // Shift the prediction, not din, so a line error cannot corrupt the local LFSR.
               sh_d    = {sh_q[2:0], pred};
               pulse_d = mismatch;
               if (bit_cnt != CNT_MAX) bit_d = bit_cnt + CNT_ONE;
               if (mismatch) begin
                  if (err_cnt != CNT_MAX) err_d = err_cnt + CNT_ONE;
                  if (cerr_q == UNLOCK_LAST) begin
                     state_d = SEARCH;
                     sh_d    = '0;
                     fill_d  = '0;
                     match_d = '0;
                     cerr_d  = '0;
                  end else begin
                     cerr_d = cerr_q + 8'd1;
                  end
               end else begin
                  cerr_d = '0;
               end
            end

            default: state_d = SEARCH;
         endcase
      end

      if (clear) begin
         bit_d = '0;
         err_d = '0;
      end
   end

   // NOTE: the reset is in the sensitivity list, so it takes effect without a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SEARCH;
         sh_q      <= '0;
         fill_q    <= '0;
         match_q   <= '0;
         cerr_q    <= '0;
         bit_cnt   <= '0;
         err_cnt   <= '0;
         err_pulse <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         sh_q      <= sh_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         cerr_q    <= cerr_d;
         bit_cnt   <= bit_d;
         err_cnt   <= err_d;
         err_pulse <= pulse_d;
      end
   end

   assign locked = (state_q == LOCKED);

endmodule
